imm_gen_stage: RTL

Parametrised, registered immediate generator for the decode stage. Accepts a 32-bit RV instruction with a 3-bit format select, produces an XLEN-wide extended immediate for I/S/B/U/J, shift-amount and CSR-zimm formats, and flags reserved selects. It sits between instruction fetch and the ALU/branch operand muxes. A valid/ready handshake with a 2-entry skid buffer sustains one immediate per cycle under backpressure, and a synchronous flush discards in-flight entries on branch redirect.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_gen_stage_if.sv | 26 ++
 rtl/imm_decode.sv | 30 +++
 rtl/imm_gen_stage.sv | 100 ++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format selects,
// skid-buffer FSM states and the held entry layout.
package imm_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned MAX_XLEN     = 64;
    localparam int unsigned MAX_TAG_W    = 64;

    typedef enum logic [2:0] {
        ImmI     = 3'b000,
        ImmS     = 3'b001,
        ImmB     = 3'b010,
        ImmU     = 3'b011,
        ImmJ     = 3'b100,
        ImmShamt = 3'b101,
        ImmZimm  = 3'b110,
        ImmRsvd  = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    // Sized for the widest configuration; narrower instances leave upper bits zero.
    typedef struct packed {
        logic [MAX_XLEN-1:0]  imm;
        logic [MAX_TAG_W-1:0] tag;
        logic                 illegal;
    } entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and operand-side handshake bundle for imm_gen_stage.
interface imm_gen_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ImmExt;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, instr, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ImmExt, out_tag, illegal
    );

    modport slave (
        input  in_valid, instr, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, ImmExt, out_tag, illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate extraction and extension for one instruction.
module imm_decode import imm_pkg::*; #(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      ImmSrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        unique case (imm_src_e'(ImmSrc))
            ImmI:     imm = XLEN'($signed({{20{instr[31]}}, instr[31:20]}));
            ImmS:     imm = XLEN'($signed({{20{instr[31]}}, instr[31:25], instr[11:7]}));
            ImmB:     imm = XLEN'($signed({{19{instr[31]}}, instr[31], instr[7],
                                           instr[30:25], instr[11:8], 1'b0}));
            ImmU:     imm = XLEN'($signed({instr[31:12], 12'b0}));
            ImmJ:     imm = XLEN'($signed({{11{instr[31]}}, instr[31], instr[19:12],
                                           instr[20], instr[30:21], 1'b0}));
            ImmShamt: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            ImmZimm:  imm = XLEN'(instr[19:15]);
            ImmRsvd:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer and branch flush.
module imm_gen_stage import imm_pkg::*; #(
    parameter int unsigned XLEN  = DEFAULT_XLEN,
    parameter int unsigned TAG_W = 32
) (
    input logic            clk,
    input logic            reset,
    input logic            flush,
    imm_gen_stage_if.slave bus
);
    state_e          state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    entry_t          in_entry;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            in_ready;
    logic            out_valid;
    logic            in_fire;
    logic            out_fire;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (bus.instr),
        .ImmSrc (bus.ImmSrc),
        .imm    (dec_imm),
        .illegal(dec_illegal)
    );

    always_comb begin
        in_entry         = '0;
        in_entry.imm     = MAX_XLEN'(dec_imm);
        in_entry.tag     = MAX_TAG_W'(bus.in_tag);
        in_entry.illegal = dec_illegal;
    end

    // in_ready is a pure function of state so no combinational path from out_ready.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_entry;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = StTwo;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.ImmExt    = main_q.imm[XLEN-1:0];
    assign bus.out_tag   = main_q.tag[TAG_W-1:0];
    assign bus.illegal   = main_q.illegal;

    // Bits above XLEN/TAG_W are always zero in this configuration.
    logic unused_main;
    assign unused_main = ^main_q;
endmodule
